pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer that replaces the single-register PC in the fetch stage. It holds the current instruction address and selects the next one from sequential increment, branch target, jump target, or an internal return-address stack (RAS). It supports fetch stalls and a configurable reset vector. It drives the instruction-memory address directly and feeds `PC_NEXT_SEQ` to the datapath for link-register writes.

## Interface
- `ADDR_WIDTH`, 32, width of all address buses.
- `RESET_VECTOR`, 0, value loaded into `PC` on reset.
- `INC`, 4, sequential increment in bytes.
- `RAS_DEPTH`, 4, number of RAS entries; must be a power of two and ≥2.

Ports:
- `CLK`  in  1  clock, rising edge active.
- `RST`  in  1  reset, asynchronous, active-low.
- `STALL`  in  1  hold `PC` and RAS; all control inputs are ignored.
- `BRANCH_TAKEN`  in  1  load `BRANCH_TARGET`.
- `BRANCH_TARGET`  in  `ADDR_WIDTH`  branch destination.
- `JUMP`  in  1  load `JUMP_TARGET`.
- `JUMP_TARGET`  in  `ADDR_WIDTH`  jump/call/fallback-return destination.
- `CALL`  in  1  push `PC+INC` onto the RAS and load `JUMP_TARGET`.
- `RET`  in  1  pop the RAS and load the popped address.
- `PC`  out  `ADDR_WIDTH`  current instruction address (registered).
- `PC_NEXT_SEQ`  out  `ADDR_WIDTH`  `PC+INC`, combinational, modulo 2^`ADDR_WIDTH`.
- `RAS_EMPTY`  out  1  RAS holds 0 valid entries.
- `RAS_FULL`  out  1  RAS holds `RAS_DEPTH` valid entries.
- `RAS_UNDERFLOW`  out  1  registered one-cycle pulse: `RET` was accepted while the RAS was empty.

## Operation
- Next-PC priority, highest first: `STALL` (hold) > `RET` > `CALL` > `JUMP` > `BRANCH_TAKEN` > sequential (`PC+INC`).
- Sequential increment wraps modulo 2^`ADDR_WIDTH`, so all-ones−3 goes to 0 with `INC`=4. There is no overflow flag.
- RAS state:
  - The RAS is a circular buffer with a top pointer and a valid count in 0..`RAS_DEPTH`.
  - Push: write `PC+INC` at top+1, advance top, increment count with saturation at `RAS_DEPTH`.
  - Push when full: overwrite the oldest entry (pointer wraps). Count stays at `RAS_DEPTH` and `RAS_FULL` stays 1.
  - Pop when count>0: next PC = entry[top], retreat top, decrement count.
  - Pop when empty: next PC = `JUMP_TARGET`, pointer and count unchanged, `RAS_UNDERFLOW` pulses the next cycle.
- `CALL` and `RET` asserted together, with count>0:
  - Next PC = entry[top].
  - entry[top] is overwritten with `PC+INC`.
  - Pointer and count are unchanged.
- `CALL` and `RET` asserted together, with the RAS empty:
  - Next PC = `JUMP_TARGET`.
  - `PC+INC` is pushed and count becomes 1.
  - `RAS_UNDERFLOW` pulses.
- `STALL`=1: `PC`, RAS contents, pointer and count are all frozen. `RAS_UNDERFLOW` is 0 the next cycle.
- The block performs no alignment checks; targets are loaded verbatim.

## Timing
- Reset (asynchronous assert on `RST` falling; synchronous effect thereafter):
  - `PC`=`RESET_VECTOR`, RAS pointer=0, count=0.
  - `RAS_EMPTY`=1, `RAS_FULL`=0, `RAS_UNDERFLOW`=0.
  - RAS entry contents are don't-care.
- Deassertion: the first rising edge with `RST`=1 applies the normal next-PC rule.
- Reset mid-operation: all state returns to reset values immediately. Any pending push or pop is lost.
- Latency: a control input sampled at rising edge N becomes visible on `PC` after edge N. `RAS_EMPTY`/`RAS_FULL` reflect the updated count after the same edge.
- `PC_NEXT_SEQ` follows `PC` combinationally within the same cycle.
- `RAS_UNDERFLOW` is high for exactly the one cycle after the offending edge.

## Configuration
- `PC_RAS_EN` defined: RAS is implemented as described above.
- `PC_RAS_EN` undefined:
  - No RAS storage.
  - `CALL` and `RET` each behave as `JUMP`, with priority unchanged.
  - `RAS_EMPTY` tied 1, `RAS_FULL` tied 0, `RAS_UNDERFLOW` tied 0.

## Test plan
- Reset/sequential: `RESET_VECTOR`=0x00400000, release `RST`, 3 idle clocks -> `PC` reads 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
- Priority and stall:
  - `BRANCH_TAKEN`(0x100) + `JUMP`(0x200) together -> `PC`=0x200.
  - Then `STALL`=1 with `RET`=1 for 2 clocks -> `PC` holds 0x200 and RAS count unchanged.
- Call/return:
  - At `PC`=0x10, `CALL` to 0x80 -> `PC`=0x80, `RAS_EMPTY`=0.
  - Then `RET` -> `PC`=0x14, `RAS_EMPTY`=1.
- Overflow wrap (`RAS_DEPTH`=4): 5 nested `CALL`s from PCs A..E, then 5 `RET`s.
  - First 4 returns yield E+4, D+4, C+4, B+4.
  - The 5th `RET` uses `JUMP_TARGET` and pulses `RAS_UNDERFLOW`.
- Simultaneous `CALL`+`RET`: with top=0x44 at `PC`=0x90 -> `PC`=0x44, count unchanged, new top=0x94.
- Async reset mid-stack: 2 entries pushed, pull `RST` low between edges -> `PC`=`RESET_VECTOR` immediately, `RAS_EMPTY`=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program counter with branch/jump select and return-address stack
// Define PC_RAS_EN to build the RAS; without it CALL and RET fall back to JUMP behaviour.
module pc_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int INC = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  STALL,
  input  logic                  BRANCH_TAKEN,
  input  logic [ADDR_WIDTH-1:0] BRANCH_TARGET,
  input  logic                  JUMP,
  input  logic [ADDR_WIDTH-1:0] JUMP_TARGET,
  input  logic                  CALL,
  input  logic                  RET,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PC_NEXT_SEQ,
  output logic                  RAS_EMPTY,
  output logic                  RAS_FULL,
  output logic                  RAS_UNDERFLOW
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] seq;
  logic                  underflow_q;
  logic                  ret_empty;

  assign seq           = pc_q + ADDR_WIDTH'(INC);
  assign PC            = pc_q;
  assign PC_NEXT_SEQ   = seq;
  assign RAS_UNDERFLOW = underflow_q;

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]         top_q;
  logic [PW:0]           count_q;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  swap;
  logic [PW-1:0]         wr_ptr;

  assign empty     = (count_q == '0);
  assign ret_empty = RET & empty;
  assign RAS_EMPTY = empty;
  assign RAS_FULL  = (count_q == (PW+1)'(RAS_DEPTH));

  // CALL+RET on a live stack swaps the top entry in place instead of pop-then-push
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    swap = 1'b0;
    if (!STALL) begin
      if (RET) begin
        if (empty)     push = CALL;
        else if (CALL) swap = 1'b1;
        else           pop  = 1'b1;
      end else if (CALL) begin
        push = 1'b1;
      end
    end
  end

  assign wr_ptr = swap ? top_q : top_q + PW'(1);

  always_comb begin
    pc_next = seq;
    if (RET)               pc_next = empty ? JUMP_TARGET : ras_mem[top_q];
    else if (CALL || JUMP) pc_next = JUMP_TARGET;
    else if (BRANCH_TAKEN) pc_next = BRANCH_TARGET;
  end

  always_ff @(posedge CLK) begin
    if (push || swap) ras_mem[wr_ptr] <= seq;
  end

  // A push onto a full stack still advances top, overwriting the oldest entry
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      top_q <= top_q + PW'(1);
      if (count_q != (PW+1)'(RAS_DEPTH)) count_q <= count_q + (PW+1)'(1);
    end else if (pop) begin
      top_q   <= top_q - PW'(1);
      count_q <= count_q - (PW+1)'(1);
    end
  end
`else
  assign ret_empty = 1'b0;
  assign RAS_EMPTY = 1'b1;
  assign RAS_FULL  = 1'b0;

  always_comb begin
    pc_next = seq;
    if (RET || CALL || JUMP) pc_next = JUMP_TARGET;
    else if (BRANCH_TAKEN)   pc_next = BRANCH_TARGET;
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q        <= RESET_VECTOR;
      underflow_q <= 1'b0;
    end else if (STALL) begin
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_next;
      underflow_q <= ret_empty;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer, default and PC_RAS_EN builds
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0040_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic        JUMP = 1'b0;
  logic [31:0] JUMP_TARGET = '0;
  logic        CALL = 1'b0;
  logic        RET = 1'b0;
  logic [31:0] PC;
  logic [31:0] PC_NEXT_SEQ;
  logic        RAS_EMPTY;
  logic        RAS_FULL;
  logic        RAS_UNDERFLOW;

  pc_sequencer #(
    .ADDR_WIDTH  (32),
    .RESET_VECTOR(RV),
    .INC         (4),
    .RAS_DEPTH   (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .STALL        (STALL),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET),
    .JUMP         (JUMP),
    .JUMP_TARGET  (JUMP_TARGET),
    .CALL         (CALL),
    .RET          (RET),
    .PC           (PC),
    .PC_NEXT_SEQ  (PC_NEXT_SEQ),
    .RAS_EMPTY    (RAS_EMPTY),
    .RAS_FULL     (RAS_FULL),
    .RAS_UNDERFLOW(RAS_UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        uf;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_pc = RV;
  logic [31:0] m_stk[$];
  logic        m_uf = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Reference model: a bounded LIFO that drops its oldest entry on overflow
  task automatic cyc(input string tag, input logic st, input logic br, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic c, input logic r);
    logic [31:0] seq;
    logic [31:0] nxt;
    exp_t        e;
    @(negedge CLK);
    STALL = st; BRANCH_TAKEN = br; BRANCH_TARGET = bt;
    JUMP = j; JUMP_TARGET = jt; CALL = c; RET = r;
    seq  = m_pc + 32'd4;
    m_uf = 1'b0;
    if (!st) begin
      nxt = seq;
`ifdef PC_RAS_EN
      if (r) begin
        if (m_stk.size() > 0) begin
          nxt = m_stk[m_stk.size()-1];
          if (c) m_stk[m_stk.size()-1] = seq;
          else   void'(m_stk.pop_back());
        end else begin
          nxt  = jt;
          m_uf = 1'b1;
          if (c) m_stk.push_back(seq);
        end
      end else if (c) begin
        nxt = jt;
        m_stk.push_back(seq);
        if (m_stk.size() > 4) void'(m_stk.pop_front());
      end else if (j) nxt = jt;
      else if (br) nxt = bt;
`else
      if (r || c || j) nxt = jt;
      else if (br)     nxt = bt;
`endif
      m_pc = nxt;
    end
    e.pc    = m_pc;
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == 4);
    e.uf    = m_uf;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (PC !== e.pc) begin
        errors++; $display("FAIL %s pc got %h want %h", e.tag, PC, e.pc);
      end
      checks++;
      if (PC_NEXT_SEQ !== e.pc + 32'd4) begin
        errors++; $display("FAIL %s next_seq got %h want %h", e.tag, PC_NEXT_SEQ, e.pc + 32'd4);
      end
      checks++;
      if (RAS_EMPTY !== e.empty) begin
        errors++; $display("FAIL %s ras_empty got %b want %b", e.tag, RAS_EMPTY, e.empty);
      end
      checks++;
      if (RAS_FULL !== e.full) begin
        errors++; $display("FAIL %s ras_full got %b want %b", e.tag, RAS_FULL, e.full);
      end
      checks++;
      if (RAS_UNDERFLOW !== e.uf) begin
        errors++; $display("FAIL %s underflow got %b want %b", e.tag, RAS_UNDERFLOW, e.uf);
      end
    end
  end

  task automatic test_reset;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    checks++;
    if (PC !== RV) begin errors++; $display("FAIL reset_pc got %h want %h", PC, RV); end
    checks++;
    if (PC_NEXT_SEQ !== 32'h0040_0004) begin errors++; $display("FAIL reset_next got %h want 00400004", PC_NEXT_SEQ); end
    checks++;
    if ({RAS_EMPTY, RAS_FULL, RAS_UNDERFLOW} !== 3'b100) begin
      errors++; $display("FAIL reset_flags got %b want 100", {RAS_EMPTY, RAS_FULL, RAS_UNDERFLOW});
    end
    RST  = 1'b1;
    m_pc = RV; m_stk.delete(); m_uf = 1'b0;
    repeat (3) idle("seq");
    @(posedge CLK); #2;
    checks++;
    if (PC !== 32'h0040_000C) begin errors++; $display("FAIL seq_third got %h want 0040000c", PC); end
  endtask

  task automatic test_wrap;
    cyc("wrap_jump", 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    idle("wrap_seq");
    idle("wrap_after");
  endtask

  task automatic test_priority;
    cyc("br_vs_jump", 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
    cyc("stall_ret0", 1'b1, 1'b0, 32'h0, 1'b0, 32'h300, 1'b0, 1'b1);
    cyc("stall_ret1", 1'b1, 1'b1, 32'h400, 1'b1, 32'h300, 1'b1, 1'b1);
    cyc("branch_only", 1'b0, 1'b1, 32'h120, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc("all_ctrl", 1'b0, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b1);
    cyc("stall_uf", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_call_ret;
    cyc("to_10", 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 1'b0);
    cyc("call_80", 1'b0, 1'b0, 32'h0, 1'b0, 32'h80, 1'b1, 1'b0);
    cyc("ret_14", 1'b0, 1'b0, 32'h0, 1'b0, 32'h999, 1'b0, 1'b1);
  endtask

  task automatic test_overflow;
    cyc("to_a", 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc("nest_call", 1'b0, 1'b0, 32'h0, 1'b0, 32'h2000 + 32'(i) * 32'h1000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc("unwind_ret", 1'b0, 1'b0, 32'h0, 1'b0, 32'h7700, 1'b0, 1'b1);
  endtask

  task automatic test_call_ret_same;
    cyc("to_40", 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
    cyc("call_90", 1'b0, 1'b0, 32'h0, 1'b0, 32'h90, 1'b1, 1'b0);
    cyc("swap_top", 1'b0, 1'b0, 32'h0, 1'b0, 32'h500, 1'b1, 1'b1);
    cyc("ret_94", 1'b0, 1'b0, 32'h0, 1'b0, 32'h600, 1'b0, 1'b1);
    cyc("swap_empty", 1'b0, 1'b0, 32'h0, 1'b0, 32'h700, 1'b1, 1'b1);
    cyc("ret_after", 1'b0, 1'b0, 32'h0, 1'b0, 32'h800, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset;
    cyc("ar_to_10", 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 1'b0);
    cyc("ar_call0", 1'b0, 1'b0, 32'h0, 1'b0, 32'h20, 1'b1, 1'b0);
    cyc("ar_call1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h30, 1'b1, 1'b0);
    @(posedge CLK); #3;
    RST = 1'b0;
    #1;
    checks++;
    if (PC !== RV) begin errors++; $display("FAIL async_pc got %h want %h", PC, RV); end
    checks++;
    if (RAS_EMPTY !== 1'b1) begin errors++; $display("FAIL async_empty got %b want 1", RAS_EMPTY); end
    STALL = 1'b0; BRANCH_TAKEN = 1'b0; JUMP = 1'b0; CALL = 1'b0; RET = 1'b0;
    m_pc = RV; m_stk.delete(); m_uf = 1'b0;
    @(posedge CLK); #2;
    RST = 1'b1;
    idle("ar_seq");
    cyc("ar_ret", 1'b0, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++)
      cyc("random", ($urandom_range(7) == 0), 1'($urandom), {$urandom_range(255), 2'b00} << 4,
          ($urandom_range(3) == 0), {$urandom_range(255), 2'b00} << 8,
          ($urandom_range(2) == 0), ($urandom_range(2) == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wrap();
    test_priority();
    test_call_ret();
    test_overflow();
    test_call_ret_same();
    test_async_reset();
    test_random();
    @(posedge CLK); #3;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
